// File: rtl/apb4_cmd_master.sv
`timescale 1ns/1ps
// apb4_cmd_master
//   APB4 requester that turns single command requests into APB4 transfers and
//   returns read data / error status on a valid-ready response channel.
//   Only one transfer is in flight at a time. Misaligned commands are answered
//   with an error without touching the bus. A completer that holds PREADY low
//   for TIMEOUT ACCESS cycles is abandoned (TIMEOUT=0 waits forever).
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | cmd_ready high, waiting for a command
//   SETUP  | PSEL high, PENABLE low, exactly one cycle
//   ACCESS | PSEL and PENABLE high, waiting for PREADY or timeout
//   RESP   | rsp_valid high, fields held until rsp_ready
//
// Ports
//   PCLK, PRESETn                    clock, async active-low reset
//   cmd_valid/ready/write/addr/wdata/strb   command channel
//   rsp_valid/ready/rdata/err/timeout       response channel
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT   APB4 requester outputs
//   PRDATA, PREADY, PSLVERR                              APB4 completer inputs
module apb4_cmd_master #(
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter int          TIMEOUT   = 64,
    parameter logic [2:0]  PPROT_VAL = 3'd0
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_W-1:0]     PADDR,
    output logic [DATA_W-1:0]     PWDATA,
    output logic [DATA_W/8-1:0]   PSTRB,
    output logic [2:0]            PPROT,
    input  logic [DATA_W-1:0]     PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    // Counter only needs to reach TIMEOUT-1; the abort happens on the edge
    // that would have counted the TIMEOUT-th wait cycle.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_W-1:0]     r_paddr;
    logic [DATA_W-1:0]     r_pwdata;
    logic [DATA_W/8-1:0]   r_pstrb;
    logic                  r_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;

    logic                  w_timeout_hit;

    assign w_timeout_hit = (TIMEOUT != 0) && (r_wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_wait_cnt <= '0;
                        if (cmd_addr[1:0] != 2'b00) begin
                            r_rsp_valid   <= 1'b1;
                            r_rsp_err     <= 1'b1;
                            r_rsp_timeout <= 1'b0;
                            r_rsp_rdata   <= '0;
                            r_state       <= S_RESP;
                        end else begin
                            r_psel    <= 1'b1;
                            r_penable <= 1'b0;
                            r_pwrite  <= cmd_write;
                            r_paddr   <= cmd_addr;
                            // Reads carry no write data or strobes on the bus.
                            r_pwdata  <= cmd_write ? cmd_wdata : '0;
                            r_pstrb   <= cmd_write ? cmd_strb : '0;
                            r_state   <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (PREADY) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= PSLVERR;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_rdata   <= (!r_pwrite && !PSLVERR) ? PRDATA : '0;
                        r_state       <= S_RESP;
                    end else if (w_timeout_hit) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_state       <= S_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid   <= 1'b0;
                        r_rsp_err     <= 1'b0;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_rdata   <= '0;
                        r_wait_cnt    <= '0;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready   = (r_state == S_IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;
    assign PSEL        = r_psel;
    assign PENABLE     = r_penable;
    assign PWRITE      = r_pwrite;
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign PSTRB       = r_pstrb;
    assign PPROT       = PPROT_VAL;

endmodule

// File: tb/tb_apb4_cmd_master.sv
`timescale 1ns/1ps
module tb_apb4_cmd_master;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_timeout;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic        PREADY, PSLVERR;

    apb4_cmd_master #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(16), .PPROT_VAL(3'd0)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // completer model: PREADY after cfg_waits low ACCESS cycles, or never if stuck
    int          acc_cnt = 0;
    int          cfg_waits = 0;
    logic        cfg_stuck = 1'b0;
    logic        cfg_err = 1'b0;
    logic [31:0] cfg_rdata = 32'h0;

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
    end

    assign PREADY  = PSEL && PENABLE && !cfg_stuck && (acc_cnt >= cfg_waits);
    assign PSLVERR = cfg_err;
    assign PRDATA  = cfg_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else             n_pass++;
    endtask

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } rsp_t;

    rsp_t sb_q[$];
    rsp_t mon_e;

    // response monitor: handshake seen mid-cycle completes on the next edge
    initial forever begin
        @(negedge PCLK);
        if (PRESETn === 1'b1 && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk_eq("sb_underflow", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk_eq("rsp_rdata",   rsp_rdata,   mon_e.rdata);
                chk_eq("rsp_err",     rsp_err,     mon_e.err);
                chk_eq("rsp_timeout", rsp_timeout, mon_e.tmo);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_strb;
    logic        exp_write;
    int          n_psel, n_pen, rsp_at;
    logic        bad_hold, bad_rdy;

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [31:0] e_rdata,
                         input logic e_err, input logic e_tmo);
        chk_eq("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
        exp_write = wr;
        exp_addr  = addr;
        exp_wdata = wr ? wdata : 32'h0;
        exp_strb  = wr ? strb : 4'h0;
        sb_q.push_back(rsp_t'{rdata: e_rdata, err: e_err, tmo: e_tmo});
        tick();
        cmd_valid = 1'b0;
        cmd_write = ~wr;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);
    endtask

    // cycle i is the cycle following accept edge T+i-1
    task automatic observe();
        n_psel = 0; n_pen = 0; rsp_at = 0; bad_hold = 1'b0; bad_rdy = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            if (cmd_ready) bad_rdy = 1'b1;
            if (rsp_valid) begin
                rsp_at = i;
                break;
            end
            if (PSEL) begin
                n_psel++;
                if (PENABLE) n_pen++;
                if (PADDR !== exp_addr || PWRITE !== exp_write ||
                    PWDATA !== exp_wdata || PSTRB !== exp_strb) bad_hold = 1'b1;
            end
            if (PENABLE && !PSEL) bad_hold = 1'b1;
            tick();
        end
        if (rsp_at == 0) chk_eq("rsp_cycle_budget", 64'd0, 64'd1);
        chk_eq("bus_fields_stable", bad_hold, 0);
        chk_eq("cmd_ready_busy", bad_rdy, 0);
    endtask

    task automatic back_to_idle();
        tick();
        chk_eq("rsp_valid_clear", rsp_valid, 0);
        chk_eq("cmd_ready_again", cmd_ready, 1);
        chk_eq("sb_drained", sb_q.size(), 0);
    endtask

    initial begin
        PRESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_strb = 4'h0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        chk_eq("rst_psel",      PSEL, 0);
        chk_eq("rst_penable",   PENABLE, 0);
        chk_eq("rst_paddr",     PADDR, 0);
        chk_eq("rst_pstrb",     PSTRB, 0);
        chk_eq("rst_rsp_valid", rsp_valid, 0);
        chk_eq("rst_rsp_rdata", rsp_rdata, 0);
        chk_eq("pprot",         PPROT, 0);
        PRESETn = 1'b1;
        tick();
        chk_eq("cmd_ready_out_of_reset", cmd_ready, 1);

        // 1: zero-wait write
        cfg_waits = 0;
        issue(1'b1, 32'h1000_0004, 32'd6, 4'hF, 32'h0, 1'b0, 1'b0);
        observe();
        chk_eq("t1_psel_cycles", n_psel, 2);
        chk_eq("t1_penable_cycles", n_pen, 1);
        chk_eq("t1_rsp_at", rsp_at, 3);
        chk_eq("t1_psel_dropped", PSEL, 0);
        back_to_idle();

        // 2: read with three wait states
        cfg_waits = 3; cfg_rdata = 32'd2;
        issue(1'b0, 32'h1020_0004, 32'hFFFF_FFFF, 4'hF, 32'd2, 1'b0, 1'b0);
        observe();
        chk_eq("t2_penable_cycles", n_pen, 4);
        chk_eq("t2_rsp_at", rsp_at, 6);
        back_to_idle();

        // 3: write error, then a normal read, then a read error
        cfg_waits = 0; cfg_err = 1'b1;
        issue(1'b1, 32'h1000_0008, 32'h0000_00A5, 4'h3, 32'h0, 1'b1, 1'b0);
        observe();
        chk_eq("t3_penable_cycles", n_pen, 1);
        back_to_idle();
        cfg_err = 1'b0; cfg_waits = 1; cfg_rdata = 32'hDEAD_BEEF;
        issue(1'b0, 32'h1000_000C, 32'h1234_5678, 4'h5, 32'hDEAD_BEEF, 1'b0, 1'b0);
        observe();
        chk_eq("t3_read_rsp_at", rsp_at, 4);
        back_to_idle();
        cfg_err = 1'b1; cfg_waits = 0; cfg_rdata = 32'h1234_5678;
        issue(1'b0, 32'h1000_0010, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
        observe();
        back_to_idle();
        cfg_err = 1'b0;

        // 4: completer never ready -> timeout after 16 ACCESS cycles
        cfg_stuck = 1'b1;
        issue(1'b0, 32'h1000_0014, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
        observe();
        chk_eq("t4_penable_cycles", n_pen, 16);
        chk_eq("t4_rsp_at", rsp_at, 18);
        chk_eq("t4_psel_dropped", PSEL, 0);
        chk_eq("t4_penable_dropped", PENABLE, 0);
        back_to_idle();
        cfg_stuck = 1'b0;

        // 5: misaligned read with a stalled response channel
        rsp_ready = 1'b0;
        issue(1'b0, 32'h1000_0006, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
        observe();
        chk_eq("t5_psel_cycles", n_psel, 0);
        chk_eq("t5_rsp_at", rsp_at, 1);
        for (int k = 0; k < 5; k++) begin
            chk_eq("t5_rsp_valid_held", rsp_valid, 1);
            chk_eq("t5_rsp_err_held", rsp_err, 1);
            chk_eq("t5_cmd_ready_low", cmd_ready, 0);
            chk_eq("t5_no_psel", PSEL, 0);
            tick();
        end
        rsp_ready = 1'b1;
        back_to_idle();

        // 6: reset during ACCESS, then a clean write
        cfg_stuck = 1'b1;
        issue(1'b0, 32'h1000_1000, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
        tick();
        tick();
        chk_eq("t6_in_access", PENABLE, 1);
        PRESETn = 1'b0;
        #1;
        chk_eq("t6_rst_psel", PSEL, 0);
        chk_eq("t6_rst_penable", PENABLE, 0);
        chk_eq("t6_rst_paddr", PADDR, 0);
        chk_eq("t6_rst_pwrite", PWRITE, 0);
        chk_eq("t6_rst_rsp_valid", rsp_valid, 0);
        chk_eq("t6_rst_cmd_ready", cmd_ready, 1);
        sb_q.delete();
        tick();
        chk_eq("t6_rst_psel_held", PSEL, 0);
        PRESETn = 1'b1;
        cfg_stuck = 1'b0; cfg_waits = 0;
        tick();
        chk_eq("t6_no_stale_rsp", rsp_valid, 0);
        issue(1'b1, 32'h1000_2000, 32'h0000_01FE, 4'hF, 32'h0, 1'b0, 1'b0);
        observe();
        chk_eq("t6_penable_cycles", n_pen, 1);
        chk_eq("t6_rsp_at", rsp_at, 3);
        back_to_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
